// File: rtl/bcd_7seg_mux.sv
// bcd_7seg_mux: multi-digit BCD display driver.
// Holds NUM_DIGITS BCD digits and scans them onto one shared 7-segment bus.
// Each digit stays enabled for REFRESH_DIV clocks. New values wait in a
// pending register and are committed only when the scan wraps to digit 0,
// so a frame never shows half of one value and half of another.
//
// Parameters:
//   NUM_DIGITS   digits scanned (>= 2)
//   REFRESH_DIV  clocks per digit (>= 2)
//   COMMON_ANODE 1: seg/an active-low, 0: seg/an active-high
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bcd_in       digit k = bcd_in[4k+3:4k], digit 0 rightmost
//   load         one-cycle strobe, captures bcd_in into pending
//   seg          {a,b,c,d,e,f,g}, registered
//   an           one-hot digit enable, registered
//   digit_idx    digit currently being scanned
//   frame_start  one-cycle pulse after the scan wraps to digit 0
// Build option:
//   LEADING_ZERO_BLANK_EN  blank leading zero digits (digit 0 always shown)

// Per-digit decoder: BCD -> active-high segment pattern.
module bcd_7seg_dec (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] pat
);
  always_comb begin
    pat = 7'b0000000;
    if (!blank) begin
      case (bcd)
        4'd0:    pat = 7'b1111110;
        4'd1:    pat = 7'b0110000;
        4'd2:    pat = 7'b1101101;
        4'd3:    pat = 7'b1111001;
        4'd4:    pat = 7'b0110011;
        4'd5:    pat = 7'b1011011;
        4'd6:    pat = 7'b1011111;
        4'd7:    pat = 7'b1110000;
        4'd8:    pat = 7'b1111111;
        4'd9:    pat = 7'b1111011;
        default: pat = 7'b0000000;
      endcase
    end
  end
endmodule

module bcd_7seg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int COMMON_ANODE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic                          load,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic                  INV     = (COMMON_ANODE != 0);
  localparam logic [6:0]            SEG_OFF = {7{INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{INV}};

  logic [CNT_W-1:0]                 cnt;
  logic                             tick, wrap;
  logic [NUM_DIGITS-1:0][3:0]       act, pend;
  logic                             pend_vld;
  logic [NUM_DIGITS-1:0]            blank;
  logic [NUM_DIGITS-1:0][6:0]       pat;
  logic [NUM_DIGITS-1:0]            onehot;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign wrap = tick && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  // Scan timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        cnt       <= '0;
        digit_idx <= wrap ? '0 : digit_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pending/active double buffer. A load coinciding with the wrap commits
  // the old pending value and keeps the new one pending for next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act      <= {NUM_DIGITS{4'hF}};
      pend     <= {NUM_DIGITS{4'hF}};
      pend_vld <= 1'b0;
    end else begin
      if (wrap && pend_vld)
        act <= pend;
      if (load) begin
        pend     <= bcd_in;
        pend_vld <= 1'b1;
      end else if (wrap) begin
        pend_vld <= 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lz[k]: digits k..NUM_DIGITS-1 of the active value are all zero.
  logic [NUM_DIGITS:0] lz;
  assign lz[NUM_DIGITS] = 1'b1;
  for (genvar k = NUM_DIGITS - 1; k >= 0; k--) begin : g_lz
    assign lz[k] = lz[k+1] & (act[k] == 4'd0);
    if (k == 0) begin : g_d0
      assign blank[k] = 1'b0;
    end else begin : g_dn
      assign blank[k] = lz[k];
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    bcd_7seg_dec u_dec (
      .bcd   (act[k]),
      .blank (blank[k]),
      .pat   (pat[k])
    );
  end

  assign onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;

  // Outputs registered from the current digit_idx: one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= INV ? ~pat[digit_idx] : pat[digit_idx];
      an  <= INV ? ~onehot : onehot;
    end
  end
endmodule

// File: doc/bcd_7seg_mux.md
Name: bcd_7seg_mux

Overview:
- Parametrised multi-digit BCD display driver.
- Holds NUM_DIGITS BCD digits and time-multiplexes them onto one shared 7-segment bus with per-digit enables.
- Supports common-anode or common-cathode polarity.
- New digit values are committed only at frame boundaries, so the display never shows a half-updated value.
- Sits between the counter/datapath logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (min 2)
REFRESH_DIV, 50000, clock cycles each digit stays enabled (min 2)
COMMON_ANODE, 1, 1 = active-low seg/an; 0 = active-high seg/an

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
bcd_in  input  4*NUM_DIGITS  digit values; digit k = bcd_in[4k+3:4k]; digit 0 is rightmost
load  input  1  one-cycle strobe; captures bcd_in into the pending register
seg  output  7  segments {a,b,c,d,e,f,g}, polarity per COMMON_ANODE
an  output  NUM_DIGITS  digit enables, one-hot active when not blanked; an[k] drives digit k
digit_idx  output  clog2(NUM_DIGITS)  index of the digit currently driven
frame_start  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (async, immediate):
  - seg and an = all segments/digits off (COMMON_ANODE=1: all ones; 0: all zeros).
  - digit_idx = 0, frame_start = 0, refresh counter = 0.
  - Active and pending registers = 4'hF per digit (blank); pending flag = 0.
- Refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count (tick), it returns to 0 and digit_idx advances by 1.
  - digit_idx wraps NUM_DIGITS-1 -> 0.
- frame_start = 1 for exactly one cycle: the cycle after a tick that wrapped digit_idx to 0.
- Segment decode (active-high pattern shown; inverted when COMMON_ANODE=1):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - 10..15 = 0000000 (blank).
- seg and an are registered. They reflect the new digit_idx one cycle after digit_idx changes (latency 1).
- A blank digit still gets its an bit asserted, so the scan timing stays uniform.
- load:
  - On load=1, bcd_in is copied to the pending register and the pending flag is set.
  - A second load before commit overwrites pending; last value wins.
- Commit:
  - On a tick that wraps digit_idx to 0 with pending flag = 1, pending is copied to active and the flag is cleared.
  - The newly active value is displayed starting with digit 0 of that frame.
- Simultaneous load and wrapping tick:
  - The old pending contents (if the flag was set) commit.
  - The new bcd_in becomes pending, flag stays 1, and it commits at the next frame.
  - If the flag was 0, nothing commits this frame.
- No load ever issued: the display stays blank (4'hF) indefinitely.
- Reset mid-frame: everything returns to reset values immediately. Scan restarts at digit 0 after rst falls.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: the active value is scanned from digit NUM_DIGITS-1 downward. Every 0 digit before the first non-zero digit is decoded as blank.
  - Digit 0 is never suppressed; value 0 shows a single "0".
  - Values 10..15 count as non-zero for this scan.
  - Suppression is computed from the active register, not the pending register.
- Undefined: zeros always display as "0"; no extra logic is present.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, COMMON_ANODE=1):
1. Assert rst mid-cycle -> seg=7'b1111111 and an=4'b1111 in the same cycle. After release, digit_idx=0 and increments every 4 clocks: 0,1,2,3,0.
2. load with bcd_in=16'h1234 during digit 2 -> digits keep showing blank until the wrap. From the frame start: digit0 seg=7'b1001100 ("4") with an=4'b1110, digit1 "3"=7'b0000110, digit2 "2"=7'b0010010, digit3 "1"=7'b1001111.
3. load 16'h5678 then load 16'h9999 within the same frame -> the next frame shows only "9999" (seg=7'b0000100 on every digit). "5678" never appears.
4. load 16'h4321 in the exact cycle of the wrapping tick while 16'h1111 is pending -> this frame shows "1111", the following frame shows "4321". frame_start pulses once per frame.
5. load 16'h00AF -> digit0 and digit1 blank (seg=7'b1111111) while an still cycles; digits 2 and 3 show "0". With LEADING_ZERO_BLANK_EN, load 16'h0070 -> digits 3 and 2 blank, digit1 "7", digit0 "0".
6. Repeat scenario 2 with COMMON_ANODE=0 -> seg and an exactly bitwise-inverted (digit0 an=4'b0001, seg=7'b0110011); reset gives seg=0, an=0.
